// File: rtl/mem_dump_ctrl_pkg.sv
// Shared state codes, ASCII constants and nibble selection for the memory dump sequencer.
package mem_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        DMP_IDLE = 3'd0,
        DMP_ADDR = 3'd1,
        DMP_CAPT = 3'd2,
        DMP_SEND = 3'd3,
        DMP_WBSY = 3'd4,
        DMP_WRDY = 3'd5
    } dmp_state_e;

    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_NUL   = 8'h00;

    // Index of the final character (LF) of a dump line.
    localparam logic [3:0] CHAR_LAST = 4'd9;

    // Nibble shown at a given character index: address nibbles 0..2, word nibbles 4..7.
    function automatic logic [3:0] dump_nibble(input logic [3:0]  idx,
                                               input logic [11:0] addr,
                                               input logic [15:0] word);
        logic [3:0] nib;
        nib = 4'h0;
        case (idx)
            4'd0:    nib = addr[11:8];
            4'd1:    nib = addr[7:4];
            4'd2:    nib = addr[3:0];
            4'd4:    nib = word[15:12];
            4'd5:    nib = word[11:8];
            4'd6:    nib = word[7:4];
            4'd7:    nib = word[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/nib2ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex digit converter.
module nib2ascii (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    // Digits map from '0', letters from 'A' (0x41 - 10 = 0x37).
    always_comb begin
        ascii = 8'h00;
        if (nib < 4'd10) begin
            ascii = 8'h30 + {4'h0, nib};
        end else begin
            ascii = 8'h37 + {4'h0, nib};
        end
    end

endmodule

// File: rtl/mem_dump_ctrl.sv
// Halted-CPU memory dump sequencer: walks an address range and streams "AAA:DDDD\r\n"
// lines through the UART transmitter ready/enable handshake.
module mem_dump_ctrl
    import mem_dump_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halted,
    input  logic [11:0] start_addr,
    input  logic [11:0] end_addr,
    output logic [11:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        tx_rdy,
    output logic [7:0]  tx_byte,
    output logic        tx_enable,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    dmp_state_e  state_r;
    logic [11:0] mem_addr_r;
    logic [11:0] end_addr_r;
    logic [15:0] word_r;
    logic [3:0]  char_idx_r;
    logic [2:0]  lat_cnt_r;
    logic [7:0]  tx_byte_r;
    logic        tx_enable_r;
    logic        busy_r;
    logic        done_r;
    logic        aborted_r;

    logic [3:0]  nib_sel_s;
    logic [7:0]  hex_s;
    logic [7:0]  char_s;

    assign nib_sel_s = dump_nibble(char_idx_r, mem_addr_r, word_r);

    nib2ascii u_nib2ascii (
        .nib   (nib_sel_s),
        .ascii (hex_s)
    );

    // Character for the current index; hex digits come from the single converter.
    always_comb begin
        char_s = ASC_NUL;
        case (char_idx_r)
            4'd0, 4'd1, 4'd2,
            4'd4, 4'd5, 4'd6, 4'd7: char_s = hex_s;
            4'd3:                   char_s = ASC_COLON;
            4'd8:                   char_s = ASC_CR;
            4'd9:                   char_s = ASC_LF;
            default:                char_s = ASC_NUL;
        endcase
    end

    // Dump sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= DMP_IDLE;
            mem_addr_r  <= 12'h000;
            end_addr_r  <= 12'h000;
            word_r      <= 16'h0000;
            char_idx_r  <= 4'd0;
            lat_cnt_r   <= 3'd0;
            tx_byte_r   <= 8'h00;
            tx_enable_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
        end else begin
            tx_enable_r <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
            case (state_r)
                DMP_IDLE: begin
                    if (start && halted) begin
                        mem_addr_r <= start_addr;
                        end_addr_r <= end_addr;
                        lat_cnt_r  <= 3'd0;
                        busy_r     <= 1'b1;
                        state_r    <= DMP_ADDR;
                    end
                end
                DMP_ADDR: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        state_r <= DMP_CAPT;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 3'd1;
                    end
                end
                DMP_CAPT: begin
                    word_r     <= mem_data;
                    char_idx_r <= 4'd0;
                    state_r    <= DMP_SEND;
                end
                // Abort is only taken here, so a strobed character always finishes its handshake.
                DMP_SEND: begin
                    if (!halted) begin
                        busy_r    <= 1'b0;
                        aborted_r <= 1'b1;
                        state_r   <= DMP_IDLE;
                    end else if (tx_rdy) begin
                        tx_byte_r   <= char_s;
                        tx_enable_r <= 1'b1;
                        state_r     <= DMP_WBSY;
                    end
                end
                DMP_WBSY: begin
                    if (!tx_rdy) begin
                        state_r <= DMP_WRDY;
                    end
                end
                DMP_WRDY: begin
                    if (tx_rdy) begin
                        if (char_idx_r == CHAR_LAST) begin
                            if (mem_addr_r == end_addr_r) begin
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= DMP_IDLE;
                            end else begin
                                mem_addr_r <= mem_addr_r + 12'd1;
                                lat_cnt_r  <= 3'd0;
                                state_r    <= DMP_ADDR;
                            end
                        end else begin
                            char_idx_r <= char_idx_r + 4'd1;
                            state_r    <= DMP_SEND;
                        end
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= DMP_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_r;
    assign tx_byte   = tx_byte_r;
    assign tx_enable = tx_enable_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Scoreboard bench for mem_dump_ctrl: expected characters are queued as stimulus is
// issued and a separate monitor pops and compares on every tx_enable strobe.
module tb_mem_dump_ctrl;

    localparam int LAT = 1;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halted;
    logic [11:0] start_addr;
    logic [11:0] end_addr;
    logic [11:0] mem_addr;
    logic [15:0] mem_data;
    logic        tx_rdy;
    logic [7:0]  tx_byte;
    logic        tx_enable;
    logic        busy;
    logic        done;
    logic        aborted;

    logic        model_rdy;
    logic        tx_hold;
    logic        slow_next;
    int          busy_len;
    logic [15:0] mem_arr [0:4095];
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;
    logic        prev_tx_en;
    int          n_tests;
    int          n_fail;
    int          strobe_cnt;
    int          done_cnt;
    int          abort_cnt;
    int          lat;
    int          base;
    int          d0;
    int          a0;
    string       hexchars = "0123456789ABCDEF";

    assign tx_rdy = model_rdy && !tx_hold;

    mem_dump_ctrl #(.MEM_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halted     (halted),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .tx_rdy     (tx_rdy),
        .tx_byte    (tx_byte),
        .tx_enable  (tx_enable),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle-latency CPU memory model.
    always @(posedge clk) mem_data <= mem_arr[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return hexchars[n];
    endfunction

    task automatic push_line(input logic [11:0] a, input logic [15:0] w, input int nchars);
        logic [7:0] line [10];
        line[0] = hex_char(a[11:8]);
        line[1] = hex_char(a[7:4]);
        line[2] = hex_char(a[3:0]);
        line[3] = 8'h3A;
        line[4] = hex_char(w[15:12]);
        line[5] = hex_char(w[11:8]);
        line[6] = hex_char(w[7:4]);
        line[7] = hex_char(w[3:0]);
        line[8] = 8'h0D;
        line[9] = 8'h0A;
        for (int i = 0; i < nchars; i++) exp_q.push_back(line[i]);
    endtask

    task automatic pulse_start(input logic [11:0] sa, input logic [11:0] ea);
        start_addr = sa;
        end_addr   = ea;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            @(negedge clk);
        end
        check(name, done_cnt, target);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (strobe_cnt >= target) break;
            @(negedge clk);
        end
        check("strobe_wait", (strobe_cnt >= target) ? 1 : 0, 1);
    endtask

    // Monitor: scoreboard compare on each strobe, plus status-pulse bookkeeping.
    initial begin
        prev_tx_en = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_enable) begin
                strobe_cnt++;
                check("strobe_width", prev_tx_en, 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_strobe: got byte %0h expected no strobe", tx_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("tx_byte", tx_byte, mon_exp);
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
            end
            if (aborted) begin
                abort_cnt++;
                check("busy_at_abort", busy, 0);
            end
            prev_tx_en = tx_enable;
        end
    end

    // UART transmitter model: goes busy after each strobe.
    initial begin
        model_rdy = 1'b1;
        slow_next = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_enable) begin
                model_rdy = 1'b0;
                busy_len  = slow_next ? 500 : 20;
                slow_next = 1'b0;
                repeat (busy_len) @(negedge clk);
                model_rdy = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; strobe_cnt = 0; done_cnt = 0; abort_cnt = 0;
        reset = 1'b1; start = 1'b0; halted = 1'b1; tx_hold = 1'b0;
        start_addr = 12'h000; end_addr = 12'h000;
        for (int i = 0; i < 4096; i++) mem_arr[i] = 16'(i * 37) ^ 16'hA5C3;
        mem_arr[12'h123] = 16'hBEEF;
        mem_arr[12'hFFE] = 16'h1234;
        mem_arr[12'hFFF] = 16'hABCD;
        mem_arr[12'h000] = 16'h0F0F;
        mem_arr[12'h001] = 16'h9A5C;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_mem_addr", mem_addr, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_tx_enable", tx_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        @(negedge clk);

        // Single line with start-to-first-strobe latency.
        push_line(12'h123, 16'hBEEF, 10);
        d0 = done_cnt;
        pulse_start(12'h123, 12'h123);
        check("start_mem_addr", mem_addr, 12'h123);
        check("start_busy", busy, 1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (tx_enable) break;
        end
        check("first_strobe_latency", lat, LAT + 2);
        wait_done(d0 + 1, 1000, "done_single");
        check("single_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("single_no_abort", abort_cnt, 0);

        // Address wrap-around across 0xFFF.
        push_line(12'hFFE, 16'h1234, 10);
        push_line(12'hFFF, 16'hABCD, 10);
        push_line(12'h000, 16'h0F0F, 10);
        push_line(12'h001, 16'h9A5C, 10);
        d0 = done_cnt;
        pulse_start(12'hFFE, 12'h001);
        wait_done(d0 + 1, 3000, "done_wrap");
        check("wrap_queue_empty", exp_q.size(), 0);
        check("wrap_mem_addr", mem_addr, 12'h001);

        // Slow transmitter stall mid-line.
        push_line(12'h040, mem_arr[12'h040], 10);
        base = strobe_cnt;
        d0 = done_cnt;
        pulse_start(12'h040, 12'h040);
        wait_strobes(base + 4, 500);
        slow_next = 1'b1;
        wait_done(d0 + 1, 3000, "done_slow");
        check("slow_queue_empty", exp_q.size(), 0);
        check("slow_strobes", strobe_cnt, base + 10);

        // Abort during WBSY of character 5.
        push_line(12'h200, mem_arr[12'h200], 6);
        base = strobe_cnt;
        d0 = done_cnt;
        a0 = abort_cnt;
        pulse_start(12'h200, 12'h201);
        wait_strobes(base + 6, 500);
        halted = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (abort_cnt > a0) break;
            @(negedge clk);
        end
        check("abort_pulse", abort_cnt, a0 + 1);
        repeat (30) @(negedge clk);
        check("abort_single", abort_cnt, a0 + 1);
        check("abort_no_done", done_cnt, d0);
        check("abort_queue_empty", exp_q.size(), 0);
        check("abort_busy", busy, 0);

        // Start while not halted is ignored.
        base = strobe_cnt;
        pulse_start(12'h500, 12'h500);
        repeat (10) @(negedge clk);
        check("nohalt_busy", busy, 0);
        check("nohalt_mem_addr", mem_addr, 12'h200);
        check("nohalt_strobes", strobe_cnt, base);
        halted = 1'b1;
        @(negedge clk);

        // Start while busy is dropped.
        push_line(12'h300, mem_arr[12'h300], 10);
        base = strobe_cnt;
        d0 = done_cnt;
        pulse_start(12'h300, 12'h300);
        wait_strobes(base + 2, 500);
        pulse_start(12'h555, 12'h556);
        check("busy_start_mem_addr", mem_addr, 12'h300);
        wait_done(d0 + 1, 1000, "done_busy_start");
        repeat (60) @(negedge clk);
        check("busy_start_idle", busy, 0);
        check("busy_start_final_addr", mem_addr, 12'h300);
        check("busy_start_queue", exp_q.size(), 0);

        // Reset while stalled in SEND, then a fresh dump.
        tx_hold = 1'b1;
        @(negedge clk);
        pulse_start(12'h7A0, 12'h7A1);
        repeat (8) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tx_hold = 1'b0;
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_tx_byte", tx_byte, 0);
        check("mid_rst_tx_enable", tx_enable, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_aborted", aborted, 0);
        @(negedge clk);
        check("post_rst_tx_enable", tx_enable, 0);
        check("post_rst_busy", busy, 0);
        push_line(12'h7A0, mem_arr[12'h7A0], 10);
        d0 = done_cnt;
        pulse_start(12'h7A0, 12'h7A0);
        wait_done(d0 + 1, 1000, "done_after_reset");
        check("after_reset_queue", exp_q.size(), 0);

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dump_ctrl.md
# mem_dump_ctrl

Halted-CPU memory dump sequencer for the ex3 FPGA system. On a start pulse it walks CPU memory from `start_addr` to `end_addr`, drives the address onto the `com_addr` path and captures each memory word. It then streams one ASCII line per word, `AAA:DDDD` followed by CR LF, through the UART transmitter using that transmitter's ready/enable handshake. It sits beside the system FSM and owns `com_addr` and `tx_byte`/`tx_enable` only while `busy` is high.

## Interface
- `MEM_LAT`, default 1: cycles from `mem_addr` change to valid `mem_data`; legal range 1..7.
- `clk` in 1: system clock (CLOCK_27).
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request pulse, e.g. a KEY falling-edge detect.
- `halted` in 1: CPU S flag clear. A dump runs only while this is high.
- `start_addr` in 12: first word address, sampled on an accepted `start`.
- `end_addr` in 12: last word address (inclusive), sampled on an accepted `start`.
- `mem_addr` out 12: address presented to CPU memory.
- `mem_data` in 16: CPU memory read data.
- `tx_rdy` in 1: UART transmitter idle.
- `tx_byte` out 8: character to transmit.
- `tx_enable` out 1: one-cycle transmit strobe.
- `busy` out 1: dump in progress.
- `done` out 1: one-cycle pulse after the last LF of a complete dump.
- `aborted` out 1: one-cycle pulse when a dump ends because `halted` fell.

## Operation
- **Reset values:** state IDLE; `mem_addr`=0, `tx_byte`=0, `tx_enable`=0, `busy`=0, `done`=0, `aborted`=0; character index 0.
- **Reset mid-dump:** everything returns to reset values on the next edge. `tx_enable` is never asserted in the cycle after reset.
- **Start acceptance:** `start` is accepted only in IDLE with `halted`=1. It is ignored in any other state or when `halted`=0. An accepted start latches `start_addr`/`end_addr`, loads `mem_addr`=`start_addr` and sets `busy`=1.
- **State machine:**
  - IDLE: on accepted start → ADDR.
  - ADDR: waits MEM_LAT cycles, then → CAPT.
  - CAPT: latches `mem_data` into the word register, clears the character index, then → SEND.
  - SEND: if `tx_rdy`=1, drives `tx_byte` and pulses `tx_enable`, then → WBSY. Otherwise it stays in SEND.
  - WBSY: waits for `tx_rdy`=0, then → WRDY.
  - WRDY: waits for `tx_rdy`=1. It then either goes → SEND with index+1, or handles end of line (index was 9) as described below.
- **End of line:**
  - If the address just dumped equals the latched `end_addr` → IDLE, pulse `done`, clear `busy`.
  - Otherwise increment `mem_addr` modulo 4096 → ADDR.
- **Character sequence (index 0..9):**
  - Indices 0–2: `mem_addr[11:8]`, `[7:4]`, `[3:0]` as hex.
  - Index 3: ':' (0x3A).
  - Indices 4–7: word nibbles, MSB first, as hex.
  - Index 8: CR (0x0D).
  - Index 9: LF (0x0A).
- **Hex encoding:** nibble 0–9 → 0x30+n; nibble A–F → 0x41+(n−10). Uppercase only.
- **Address range:**
  - Addresses wrap: `end_addr` < `start_addr` dumps `start_addr`..0xFFF, then 0x000..`end_addr`.
  - `start_addr`==`end_addr` dumps exactly one line.
  - The full range is 4096 lines maximum.
- **Abort:** `halted` is sampled in SEND.
  - If 0 → IDLE, pulse `aborted`, clear `busy`. No `tx_enable` is issued.
  - A character already strobed always completes its WBSY/WRDY handshake first. Partial characters never occur.
- **Simultaneous events:** `reset` dominates everything. `start` during `busy` is dropped and not queued.

## Timing
- **Start to first strobe:** with `start` sampled at edge 0 and `tx_rdy` held 1:
  - `mem_addr` is valid after edge 1.
  - CAPT occurs in cycle MEM_LAT+1.
  - The first `tx_enable` is high in cycle MEM_LAT+2.
- **Strobe width:** `tx_enable` is high exactly one cycle per character. It is registered, with no combinational path from `tx_rdy`.
- **Line-to-line gap:** from the LF handshake completion (WRDY seeing `tx_rdy`=1) to the next line's first strobe is MEM_LAT+2 cycles.
- **Status pulses:** `done` and `aborted` are registered single-cycle pulses coincident with `busy` falling.
- **Address stability:** `mem_addr` holds stable from ADDR through the end of that word's line.

## Structure
- **Shared defines in `def_ex3.v`:**
  - State codes `DMP_IDLE`, `DMP_ADDR`, `DMP_CAPT`, `DMP_SEND`, `DMP_WBSY`, `DMP_WRDY` (3-bit).
  - ASCII constants `ASC_COLON`, `ASC_CR`, `ASC_LF`.
- **Sub-module:** one combinational sub-module, `nib2ascii` (4-bit nibble → 8-bit ASCII), instanced once on the selected nibble.
- **Latency counter:** 3 bits, sized for MEM_LAT ≤ 7.

## Test plan
- **Single line:** MEM_LAT=1, memory[0x123]=0xBEEF, start with start=end=0x123, transmitter model drops `tx_rdy` 1 cycle after strobe for 20 cycles → bytes 31 32 33 3A 42 45 45 46 0D 0A, then one `done` pulse, `busy`=0.
- **Wrap-around:** start=0xFFE, end=0x001 → four lines, addresses FFE, FFF, 000, 001, in order, then `done`.
- **Slow transmitter:** `tx_rdy` held low 500 cycles mid-line → no extra strobes, no dropped or duplicated characters.
- **Abort:** `halted` falls during the WBSY of character 5 → that character completes, no further strobe, `aborted` pulses once, `done` stays 0.
- **Ignored starts:** `start` while `busy`, and `start` with `halted`=0 → ignored; outputs unchanged.
- **Reset mid-dump:** `reset` pulse during SEND → next cycle all outputs 0, state IDLE. A new start then dumps correctly.
